exp_series_seq: RTL and testbench
=================================

// Module: exp_series_seq
// PURPOSE
//  Multi-channel, parametrised controller for the e^x Taylor-series datapath: r = 1 + sum t_n, with t_n = t_(n-1)*x*(1/n).
//  Loads CH operands, then runs N_TERMS multiply/multiply/add iterations per channel on one shared datapath.
//  Counts terms internally and absorbs a multicycle multiplier; drives the datapath's load/init/clear strobes.
// PARAMETERS
//  N_TERMS   8  series terms added after r=1 per channel (>=1)
//  MULT_LAT  1  cycles per multiply; ldt fires in the last one (>=1)
//  CH        1  channels processed back-to-back (>=1)
//  CNT_W     localparam $clog2(N_TERMS+1); CH_W localparam max(1,$clog2(CH))
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      start/load request (level)
//  t_zero    in   1      datapath term register == 0 (used only with EXP_SEQ_EARLY_EXIT_EN)
//  done      out  1      high in IDLE
//  busy      out  1      ~done
//  zx,initx,ldx / zt,initt,ldt / zr,initr,ldr  out 1 each  clear/init/load strobes for x, t, r regs
//  zc,enc    out  1      clear / increment for the datapath term counter (1/n lookup)
//  s         out  1      multiplier operand select: 0 = t*x, 1 = t*(1/n)
//  ch_sel    out  CH_W   channel index for the x bank and the result write
//  term_idx  out  CNT_W  terms added so far in the current channel
//  res_valid out  1      1-cycle pulse when the result for ch_sel is final
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ch_sel=0, term_idx=0, wait timer=0. In IDLE: zx=zt=zc=done=1; all other outputs 0.
//  Strobes not listed for a state are 0. Moore outputs only; t_zero and start affect only ns.
//  IDLE:   start=1 -> LOAD; else stay.
//  LOAD:   ldx=1 while load count < CH; ch_sel = load count, incremented each cycle and saturating at CH-1.
//          ldx=0 once CH loads are done; stay while start=1.
//          start=0 -> BEGIN with ch_sel:=0. start dropped before CH loads: unloaded channels keep their zeroed x.
//  BEGIN:  initr=initt=1, zc=1, term_idx:=0 -> MUL1.
//  MUL1:   s=0 for MULT_LAT cycles; ldt=1 in the last one only -> MUL2.
//  MUL2:   s=1, same timing -> ADD.
//  ADD:    ldr=1, enc=1, term_idx+1.
//          Next state: if new term_idx==N_TERMS -> NEXT; else MUL1.
//  NEXT:   res_valid=1.
//          If ch_sel==CH-1 -> IDLE, ch_sel:=0; else ch_sel+1 -> BEGIN.
//  Latency (CH=1): BEGIN to IDLE = 2 + N_TERMS*(2*MULT_LAT+1) cycles.
//  start is ignored outside IDLE and LOAD; a new start is accepted on the first IDLE cycle.
//  term_idx never exceeds N_TERMS. ch_sel never exceeds CH-1.
// CONFIGURATION
//  EXP_SEQ_EARLY_EXIT_EN defined: in ADD, t_zero=1 forces -> NEXT regardless of term_idx (term underflow ends the series).
//  Not defined: t_zero is ignored; every channel runs exactly N_TERMS terms. The port exists in both builds.
// STRUCTURE
//  exp_seq_pkg: state enum typedef {IDLE,LOAD,BEGIN,MUL1,MUL2,ADD,NEXT} (3-bit) and a latency-formula function for the bench.
//  Sub-module exp_wait_timer: MULT_LAT down-counter with load/last outputs, instantiated once for MUL1/MUL2.
// TESTING
//  1 N_TERMS=8, MULT_LAT=1, CH=1: start high 2 cycles then low -> ldx pulses once; 8x(MUL1,MUL2,ADD); res_valid once; IDLE 26 cycles after BEGIN.
//  2 MULT_LAT=3: each MUL state lasts 3 cycles; ldt only in the 3rd, s steady throughout; BEGIN to IDLE = 58 cycles.
//  3 CH=4, start high 6 cycles: ldx on 4 cycles with ch_sel 0..3, then 0; channels run 0..3; res_valid 4 times; IDLE follows ch_sel=3.
//  4 rst pulsed mid-MUL2 of channel 2 -> same-cycle IDLE, done=1, ch_sel=0, term_idx=0; a fresh start completes normally.
//  5 start toggled during MUL1/ADD -> no state effect; start held in IDLE -> LOAD in the next cycle.
//  6 EXP_SEQ_EARLY_EXIT_EN defined, t_zero=1 at ADD with term_idx=3 -> NEXT, res_valid; undefined -> runs to 8.

Source files
------------

// File: rtl/exp_seq_pkg.sv
// Shared types and helpers for the e^x series sequencer.
package exp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, BEGIN, MUL1, MUL2, ADD, NEXT
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Cycles from entering BEGIN to returning to IDLE for a single channel.
  function automatic int seq_latency(input int n_terms, input int mult_lat);
    return 2 + n_terms * (2 * mult_lat + 1);
  endfunction

endpackage

// File: rtl/exp_wait_timer.sv
// Down-counter that paces a multicycle multiply; last is high in the final cycle.
module exp_wait_timer #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last
);
  localparam int W = (LAT > 1) ? $clog2(LAT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= W'(LAT - 1);
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/exp_series_seq.sv
// Controller for the shared e^x Taylor-series datapath across CH channels.
// Optional: define EXP_SEQ_EARLY_EXIT_EN to end a channel when the term underflows to zero.
module exp_series_seq
  import exp_seq_pkg::*;
#(
  parameter  int N_TERMS  = 8,
  parameter  int MULT_LAT = 1,
  parameter  int CH       = 1,
  localparam int CNT_W    = $clog2(N_TERMS + 1),
  localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             t_zero,
  output logic             done,
  output logic             busy,
  output logic             zx,
  output logic             initx,
  output logic             ldx,
  output logic             zt,
  output logic             initt,
  output logic             ldt,
  output logic             zr,
  output logic             initr,
  output logic             ldr,
  output logic             zc,
  output logic             enc,
  output logic             s,
  output logic [CH_W-1:0]  ch_sel,
  output logic [CNT_W-1:0] term_idx,
  output logic             res_valid
);
  localparam int LD_W = $clog2(CH + 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH - 1);

  state_t            state, ns;
  logic [LD_W-1:0]   ld_cnt;
  logic [CNT_W-1:0]  term_nx;
  logic              mul_last, tmr_load, early;

`ifdef EXP_SEQ_EARLY_EXIT_EN
  assign early = t_zero;
`else
  logic unused_t_zero;
  assign unused_t_zero = t_zero;
  assign early = 1'b0;
`endif

  assign term_nx = term_idx + 1'b1;
  // Reload the timer everywhere except mid-multiply, so each MUL state starts fresh.
  assign tmr_load = !(((state == MUL1) || (state == MUL2)) && !mul_last);

  exp_wait_timer #(.LAT(MULT_LAT)) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .last (mul_last)
  );

  always_comb begin
    ns        = state;
    done      = 1'b0;
    zx        = 1'b0;
    initx     = 1'b0;
    ldx       = 1'b0;
    zt        = 1'b0;
    initt     = 1'b0;
    ldt       = 1'b0;
    zr        = 1'b0;
    initr     = 1'b0;
    ldr       = 1'b0;
    zc        = 1'b0;
    enc       = 1'b0;
    s         = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        done = 1'b1;
        zx   = 1'b1;
        zt   = 1'b1;
        zc   = 1'b1;
        if (start) ns = LOAD;
      end
      LOAD: begin
        ldx = (ld_cnt < LD_W'(CH));
        if (!start) ns = BEGIN;
      end
      BEGIN: begin
        initr = 1'b1;
        initt = 1'b1;
        zc    = 1'b1;
        ns    = MUL1;
      end
      MUL1: begin
        s   = 1'b0;
        ldt = mul_last;
        if (mul_last) ns = MUL2;
      end
      MUL2: begin
        s   = 1'b1;
        ldt = mul_last;
        if (mul_last) ns = ADD;
      end
      ADD: begin
        ldr = 1'b1;
        enc = 1'b1;
        ns  = ((term_nx == CNT_W'(N_TERMS)) || early) ? NEXT : MUL1;
      end
      NEXT: begin
        res_valid = 1'b1;
        ns = (ch_sel == CH_LAST) ? IDLE : BEGIN;
      end
      default: ns = IDLE;
    endcase
  end

  assign busy = ~done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ch_sel   <= '0;
      term_idx <= '0;
      ld_cnt   <= '0;
    end else begin
      state <= ns;
      case (state)
        IDLE: begin
          ld_cnt <= '0;
          ch_sel <= '0;
        end
        LOAD: begin
          if (ldx) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ch_sel != CH_LAST) ch_sel <= ch_sel + 1'b1;
          end
          if (!start) ch_sel <= '0;
        end
        BEGIN: term_idx <= '0;
        ADD:   term_idx <= term_nx;
        NEXT:  ch_sel <= (ch_sel == CH_LAST) ? '0 : ch_sel + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_series_seq.sv
// Directed bench: three sequencer configurations (base, MULT_LAT=3, CH=4).
module tb_exp_series_seq;
  import exp_seq_pkg::*;

  typedef struct packed {
    logic done, busy, s, ldx, ldt, ldr, enc, initr, initt, zc, zx, zt, zr, rv;
    logic [1:0] ch;
    logic [3:0] ti;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start1 = 1'b0, start2 = 1'b0, start3 = 1'b0, tz1 = 1'b0;
  logic [2:0] done, busy, zx, initx, ldx, zt, initt, ldt, zr, initr, ldr, zc, enc, s, rv;
  logic       ch_a, ch_b;
  logic [1:0] ch_c;
  logic [3:0] ti_a, ti_b, ti_c;

  int n_chk = 0, n_fail = 0;
  obs_t tr [0:511];
  bit tog_en = 1'b0;

  exp_series_seq #(.N_TERMS(8), .MULT_LAT(1), .CH(1)) d1 (
    .clk(clk), .rst(rst), .start(start1), .t_zero(tz1), .done(done[0]), .busy(busy[0]),
    .zx(zx[0]), .initx(initx[0]), .ldx(ldx[0]), .zt(zt[0]), .initt(initt[0]), .ldt(ldt[0]),
    .zr(zr[0]), .initr(initr[0]), .ldr(ldr[0]), .zc(zc[0]), .enc(enc[0]), .s(s[0]),
    .ch_sel(ch_a), .term_idx(ti_a), .res_valid(rv[0]));

  exp_series_seq #(.N_TERMS(8), .MULT_LAT(3), .CH(1)) d2 (
    .clk(clk), .rst(rst), .start(start2), .t_zero(1'b0), .done(done[1]), .busy(busy[1]),
    .zx(zx[1]), .initx(initx[1]), .ldx(ldx[1]), .zt(zt[1]), .initt(initt[1]), .ldt(ldt[1]),
    .zr(zr[1]), .initr(initr[1]), .ldr(ldr[1]), .zc(zc[1]), .enc(enc[1]), .s(s[1]),
    .ch_sel(ch_b), .term_idx(ti_b), .res_valid(rv[1]));

  exp_series_seq #(.N_TERMS(8), .MULT_LAT(1), .CH(4)) d3 (
    .clk(clk), .rst(rst), .start(start3), .t_zero(1'b0), .done(done[2]), .busy(busy[2]),
    .zx(zx[2]), .initx(initx[2]), .ldx(ldx[2]), .zt(zt[2]), .initt(initt[2]), .ldt(ldt[2]),
    .zr(zr[2]), .initr(initr[2]), .ldr(ldr[2]), .zc(zc[2]), .enc(enc[2]), .s(s[2]),
    .ch_sel(ch_c), .term_idx(ti_c), .res_valid(rv[2]));

  function automatic obs_t pick(input int d);
    obs_t o;
    o = '{done: done[d], busy: busy[d], s: s[d], ldx: ldx[d], ldt: ldt[d], ldr: ldr[d],
          enc: enc[d], initr: initr[d], initt: initt[d], zc: zc[d], zx: zx[d], zt: zt[d],
          zr: zr[d], rv: rv[d], ch: 2'b00, ti: 4'h0};
    case (d)
      0:       begin o.ch = {1'b0, ch_a}; o.ti = ti_a; end
      1:       begin o.ch = {1'b0, ch_b}; o.ti = ti_b; end
      default: begin o.ch = ch_c;         o.ti = ti_c; end
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trace from the current cycle (index 0) until done, bounded.
  task automatic run_done(input int d, input int maxc, output int cyc);
    obs_t o;
    cyc = 0;
    o = pick(d);
    tr[0] = o;
    while (!o.done && cyc < maxc) begin
      tick();
      cyc++;
      if (tog_en) start1 = (cyc % 2 == 1);
      o = pick(d);
      tr[cyc] = o;
    end
    if (!o.done) chk("run_timeout", 0, 1);
  endtask

  task automatic count_tr(input int n, output int nldt, output int nldr, output int nrv);
    nldt = 0; nldr = 0; nrv = 0;
    for (int i = 0; i <= n; i++) begin
      nldt += int'(tr[i].ldt);
      nldr += int'(tr[i].ldr);
      nrv  += int'(tr[i].rv);
    end
  endtask

  initial begin
    obs_t o;
    int cyc, nldt, nldr, nrv, k, rvi;

    // Reset state of all three instances
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      o = pick(d);
      chk("rst_done", o.done, 1);
      chk("rst_busy", o.busy, 0);
      chk("rst_zx_zt_zc", {o.zx, o.zt, o.zc}, 7);
      chk("rst_strobes", {o.ldx, o.ldt, o.ldr, o.enc, o.initr, o.zr, o.rv}, 0);
      chk("rst_ch", o.ch, 0);
      chk("rst_ti", o.ti, 0);
    end

    // 1: base config, start high 2 cycles
    start1 = 1'b1;
    tick(); o = pick(0);
    chk("t1_ldx0", o.ldx, 1);
    chk("t1_busy", o.busy, 1);
    tick(); o = pick(0);
    chk("t1_ldx1", o.ldx, 0);
    start1 = 1'b0;
    tick(); o = pick(0);
    chk("t1_begin", {o.initr, o.initt, o.zc}, 7);
    run_done(0, 300, cyc);
    chk("t1_lat", cyc, 26);
    chk("t1_lat_fn", cyc, seq_latency(8, 1));
    chk("t1_mul1", {tr[1].s, tr[1].ldt}, 1);
    chk("t1_mul2", {tr[2].s, tr[2].ldt}, 3);
    chk("t1_add", {tr[3].ldr, tr[3].enc, tr[3].ti}, 48);
    chk("t1_ti1", tr[4].ti, 1);
    count_tr(cyc, nldt, nldr, nrv);
    chk("t1_nldt", nldt, 16);
    chk("t1_nldr", nldr, 8);
    chk("t1_nrv", nrv, 1);
    chk("t1_rv_last", tr[cyc-1].rv, 1);
    chk("t1_ti_end", tr[cyc].ti, 8);

    // 2: MULT_LAT=3
    start2 = 1'b1;
    tick(); tick();
    start2 = 1'b0;
    tick(); o = pick(1);
    chk("t2_begin", o.initr, 1);
    run_done(1, 300, cyc);
    chk("t2_lat", cyc, 58);
    for (int i = 1; i <= 3; i++) begin
      chk("t2_mul1_s", tr[i].s, 0);
      chk("t2_mul1_ldt", tr[i].ldt, (i == 3) ? 1 : 0);
      chk("t2_mul2_s", tr[i+3].s, 1);
      chk("t2_mul2_ldt", tr[i+3].ldt, (i == 3) ? 1 : 0);
    end
    chk("t2_add", tr[7].ldr, 1);
    count_tr(cyc, nldt, nldr, nrv);
    chk("t2_nldt", nldt, 16);
    chk("t2_nldr", nldr, 8);

    // 3: CH=4, start high 6 cycles
    start3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) start3 = 1'b0;
      o = pick(2);
      chk("t3_ldx", o.ldx, (i < 4) ? 1 : 0);
      chk("t3_load_ch", o.ch, (i < 4) ? i : 3);
    end
    tick(); o = pick(2);
    chk("t3_begin_ch", o.ch, 0);
    chk("t3_begin", o.initr, 1);
    run_done(2, 400, cyc);
    chk("t3_lat", cyc, 104);
    rvi = 0;
    for (int i = 0; i <= cyc; i++) begin
      if (tr[i].rv) begin
        chk("t3_rv_ch", tr[i].ch, rvi);
        rvi++;
      end
    end
    chk("t3_nrv", rvi, 4);
    chk("t3_last_ch", tr[cyc-1].ch, 3);
    chk("t3_idle_ch", tr[cyc].ch, 0);

    // 4: async reset mid-MUL2 of channel 2
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    k = 0;
    do begin
      tick(); k++; o = pick(2);
    end while (!(o.s && o.ch == 2 && o.ti == 2) && k < 300);
    chk("t4_reach", int'(o.s && o.ch == 2 && o.ti == 2), 1);
    rst = 1'b1;
    #1; o = pick(2);
    chk("t4_rst_done", o.done, 1);
    chk("t4_rst_ch", o.ch, 0);
    chk("t4_rst_ti", o.ti, 0);
    tick();
    rst = 1'b0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    run_done(2, 400, cyc);
    chk("t4_lat", cyc, 104);
    count_tr(cyc, nldt, nldr, nrv);
    chk("t4_nrv", nrv, 4);

    // 5: start toggling while running, then held in IDLE
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tog_en = 1'b1;
    run_done(0, 300, cyc);
    tog_en = 1'b0;
    chk("t5_lat", cyc, 26);
    count_tr(cyc, nldt, nldr, nrv);
    chk("t5_nrv", nrv, 1);
    chk("t5_nldr", nldr, 8);
    start1 = 1'b1;
    tick(); o = pick(0);
    chk("t5_reload_ldx", o.ldx, 1);
    chk("t5_reload_done", o.done, 0);
    start1 = 1'b0;
    tick();
    run_done(0, 300, cyc);
    chk("t5_lat2", cyc, 26);

    // 6: t_zero at ADD with term_idx=3
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    k = 0;
    do begin
      tick(); k++; o = pick(0);
    end while (!(o.ldr && o.ti == 3) && k < 300);
    chk("t6_reach", int'(o.ldr && o.ti == 3), 1);
    tz1 = 1'b1;
    tick();
    tz1 = 1'b0;
    o = pick(0);
    chk("t6_ti", o.ti, 4);
`ifdef EXP_SEQ_EARLY_EXIT_EN
    chk("t6_early_rv", o.rv, 1);
    run_done(0, 300, cyc);
    chk("t6_early_end_ti", tr[cyc].ti, 4);
`else
    chk("t6_no_early_rv", o.rv, 0);
    chk("t6_no_early_mul1", {o.s, o.ldt}, 1);
    run_done(0, 300, cyc);
    chk("t6_full_end_ti", tr[cyc].ti, 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
